swbh_rmw: RTL and testbench

- Store-side partner to the load byte/halfword extractor in the multi-cycle CPU.
- Takes a store request (sw/sb/sh) and writes it to word-organised data memory.
- A full word is written directly. A byte or halfword uses a read-modify-write sequence: read the word, merge the new lane, write the word back.
- Sits between the datapath store stage and the data-memory port, and stalls the control FSM through `busy`.

---
 rtl/swbh_rmw_pkg.sv | 24 ++
 rtl/swbh_rmw_if.sv | 28 ++
 rtl/swbh_merge.sv | 32 +++
 rtl/swbh_rmw.sv | 118 +++++++++++
 tb/tb_swbh_rmw.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/swbh_rmw_pkg.sv
// ============================================================================
// swbh_rmw_pkg : store size codes (shared with the load extractor) and the
//                read-modify-write FSM state encoding.
// Revision     : 1.0
// ============================================================================
`default_nettype none

package swbh_rmw_pkg;

  localparam logic [1:0] SZ_WORD    = 2'd0;
  localparam logic [1:0] SZ_BYTE    = 2'd1;
  localparam logic [1:0] SZ_HALF    = 2'd2;
  localparam logic [1:0] SZ_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/swbh_rmw_if.sv
// ============================================================================
// swbh_rmw_if : word-organised data-memory port (strobe held until ready).
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface swbh_rmw_if #(
  parameter int AW = 32
) ();
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_ready;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

`default_nettype wire

// File: rtl/swbh_merge.sv
// ============================================================================
// swbh_merge : combinational lane merge of store data into an existing word.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module swbh_merge
  import swbh_rmw_pkg::*;
(
  input  logic [1:0]  cnt,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] old,
  output logic [31:0] merged
);

  always_comb begin
    merged = old;
    case (cnt)
      SZ_WORD: merged = wdata;
      SZ_BYTE: merged[{lane, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      default: merged = old;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/swbh_rmw.sv
// ============================================================================
// swbh_rmw : sw/sb/sh store unit; byte and halfword go through read-modify-
//            write. Option macro SWBH_MISALIGN_TRAP_EN rejects misaligned sw/sh.
// Revision : 1.0
// ============================================================================
`default_nettype none

module swbh_rmw
  import swbh_rmw_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       cnt,
  input  logic [AW-1:0]    addr,
  input  logic [DW-1:0]    wdata,
  output logic             busy,
  output logic             done,
  output logic             err,
  swbh_rmw_if.master       mem
);

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_cnt;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [31:0]     r_word;
  logic            r_err;
  logic            w_accept;
  logic            w_reject;
  logic [31:0]     w_merged;

  assign w_accept = (r_state == ST_IDLE) && start;

`ifdef SWBH_MISALIGN_TRAP_EN
  assign w_reject = (cnt == SZ_ILLEGAL)
                 || ((cnt == SZ_HALF) && addr[0])
                 || ((cnt == SZ_WORD) && (addr[1:0] != 2'b00));
`else
  assign w_reject = (cnt == SZ_ILLEGAL);
`endif

  swbh_merge u_merge (
    .cnt    (r_cnt),
    .lane   (r_addr[1:0]),
    .wdata  (r_wdata),
    .old    (mem.mem_rdata),
    .merged (w_merged)
  );

  // r_word is preloaded with the store data so a plain sw needs no merge step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 2'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_word  <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt   <= cnt;
        r_addr  <= addr;
        r_wdata <= wdata;
        r_word  <= wdata;
        r_err   <= w_reject;
      end
      if ((r_state == ST_READ) && mem.mem_ready) begin
        r_word <= w_merged;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    mem.mem_rd = 1'b0;
    mem.mem_wr = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_reject)             w_next = ST_DONE;
          else if (cnt == SZ_WORD)  w_next = ST_WRITE;
          else                      w_next = ST_READ;
        end
      end
      ST_READ: begin
        mem.mem_rd = 1'b1;
        busy       = 1'b1;
        if (mem.mem_ready) w_next = ST_WRITE;
      end
      ST_WRITE: begin
        mem.mem_wr = 1'b1;
        busy       = 1'b1;
        if (mem.mem_ready) w_next = ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        err    = r_err;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign mem.mem_addr  = {r_addr[AW-1:2], 2'b00};
  assign mem.mem_wdata = r_word;

endmodule

`default_nettype wire

// File: tb/tb_swbh_rmw.sv
// ============================================================================
// tb_swbh_rmw : directed self-checking bench for the swbh_rmw store unit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_swbh_rmw;
  import swbh_rmw_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  cnt   = 2'd0;
  logic [31:0] addr  = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, err;

  swbh_rmw_if #(.AW(32)) mem_if ();

  swbh_rmw #(.AW(32), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .cnt   (cnt),
    .addr  (addr),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .mem   (mem_if)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  int          rd_cycles, wr_cycles, done_cyc;
  logic [31:0] rd_addr, wr_addr, wr_data;
  bit          overlap, busy_bad, err_seen, err_stray, wdata_unstable;
  bit          post_busy, post_done, post_wr;

  // Drives one request and plays memory; cycle 1 is the cycle start is high.
  task automatic run_store(input logic [1:0] c, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] memval,
                           input int rd_waits, input int wr_waits, input int hold);
    int cyc, rd_left, wr_left;
    bit finished;
    rd_cycles = 0; wr_cycles = 0; done_cyc = 0;
    rd_addr = 32'hx; wr_addr = 32'hx; wr_data = 32'hx;
    overlap = 0; busy_bad = 0; err_seen = 0; err_stray = 0; wdata_unstable = 0;
    finished = 0;
    @(negedge clk);
    start = 1'b1; cnt = c; addr = a; wdata = d; mem_if.mem_ready = 1'b0;
    cyc = 1; rd_left = rd_waits; wr_left = wr_waits;
    while (!finished && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = (cyc <= hold);
      mem_if.mem_ready = 1'b0;
      if (mem_if.mem_rd && mem_if.mem_wr) overlap = 1;
      if (err && !done) err_stray = 1;
      if (done) begin
        done_cyc = cyc; err_seen = err; finished = 1;
        if (busy) busy_bad = 1;
      end else begin
        if (!busy) busy_bad = 1;
        if (mem_if.mem_rd) begin
          rd_cycles++;
          rd_addr = mem_if.mem_addr;
          mem_if.mem_rdata = memval;
          if (rd_left == 0) mem_if.mem_ready = 1'b1; else rd_left--;
        end
        if (mem_if.mem_wr) begin
          if (wr_cycles > 0 && mem_if.mem_wdata !== wr_data) wdata_unstable = 1;
          wr_cycles++;
          wr_addr = mem_if.mem_addr;
          wr_data = mem_if.mem_wdata;
          if (wr_left == 0) mem_if.mem_ready = 1'b1; else wr_left--;
        end
      end
    end
    @(negedge clk);
    start = 1'b0; mem_if.mem_ready = 1'b0;
    post_busy = busy; post_done = done; post_wr = mem_if.mem_wr;
  endtask

  task automatic test_reset();
    logic [5:0] flags;
    mem_if.mem_ready = 1'b0; mem_if.mem_rdata = 32'd0;
    rst_n = 1'b0;
    #12;
    flags = {busy, done, err, mem_if.mem_rd, mem_if.mem_wr, 1'b0};
    vectors++;
    if (flags !== 6'b0) begin miscompares++; $display("FAIL reset_ctrl: got %b expected %b", flags, 6'b0); end
    vectors++;
    if (mem_if.mem_addr !== 32'd0) begin miscompares++; $display("FAIL reset_addr: got %h expected %h", mem_if.mem_addr, 32'd0); end
    vectors++;
    if (mem_if.mem_wdata !== 32'd0) begin miscompares++; $display("FAIL reset_wdata: got %h expected %h", mem_if.mem_wdata, 32'd0); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sw();
    run_store(SZ_WORD, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 1);
    vectors++;
    if (rd_cycles !== 0) begin miscompares++; $display("FAIL sw_rd: got %0d expected 0", rd_cycles); end
    vectors++;
    if (wr_cycles !== 1) begin miscompares++; $display("FAIL sw_wr: got %0d expected 1", wr_cycles); end
    vectors++;
    if (wr_addr !== 32'h100) begin miscompares++; $display("FAIL sw_addr: got %h expected %h", wr_addr, 32'h100); end
    vectors++;
    if (wr_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL sw_data: got %h expected %h", wr_data, 32'hDEADBEEF); end
    vectors++;
    if (done_cyc !== 3) begin miscompares++; $display("FAIL sw_latency: got %0d expected 3", done_cyc); end
    vectors++;
    if ({err_seen, err_stray, busy_bad, overlap} !== 4'b0) begin
      miscompares++; $display("FAIL sw_flags: got %b expected 0000", {err_seen, err_stray, busy_bad, overlap});
    end
  endtask

  task automatic test_sb();
    run_store(SZ_BYTE, 32'h102, 32'h000000AB, 32'h11223344, 0, 0, 1);
    vectors++;
    if (rd_cycles !== 1 || rd_addr !== 32'h100) begin
      miscompares++; $display("FAIL sb_read: got %0d@%h expected 1@%h", rd_cycles, rd_addr, 32'h100);
    end
    vectors++;
    if (wr_data !== 32'h11AB3344 || wr_addr !== 32'h100) begin
      miscompares++; $display("FAIL sb_write: got %h@%h expected %h@%h", wr_data, wr_addr, 32'h11AB3344, 32'h100);
    end
    vectors++;
    if (done_cyc !== 4) begin miscompares++; $display("FAIL sb_latency: got %0d expected 4", done_cyc); end
    vectors++;
    if ({err_seen, busy_bad, overlap} !== 3'b0) begin
      miscompares++; $display("FAIL sb_flags: got %b expected 000", {err_seen, busy_bad, overlap});
    end
  endtask

  task automatic test_sh_wait();
    run_store(SZ_HALF, 32'h106, 32'hFFFF5566, 32'h11223344, 2, 0, 1);
    vectors++;
    if (rd_cycles !== 3) begin miscompares++; $display("FAIL sh_rd_hold: got %0d expected 3", rd_cycles); end
    vectors++;
    if (wr_data !== 32'h55663344 || wr_addr !== 32'h104) begin
      miscompares++; $display("FAIL sh_write: got %h@%h expected %h@%h", wr_data, wr_addr, 32'h55663344, 32'h104);
    end
    vectors++;
    if (done_cyc !== 6) begin miscompares++; $display("FAIL sh_latency: got %0d expected 6", done_cyc); end
    vectors++;
    if ({busy_bad, overlap} !== 2'b0) begin
      miscompares++; $display("FAIL sh_flags: got %b expected 00", {busy_bad, overlap});
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] exp_word [4];
    exp_word[0] = 32'h112233AB; exp_word[1] = 32'h1122AB44;
    exp_word[2] = 32'h11AB3344; exp_word[3] = 32'hAB223344;
    for (int lane = 0; lane < 4; lane++) begin
      run_store(SZ_BYTE, 32'h200 + lane, 32'h9876_54AB, 32'h11223344, 0, (lane == 3) ? 1 : 0, 1);
      vectors++;
      if (wr_data !== exp_word[lane] || wr_addr !== 32'h200) begin
        miscompares++;
        $display("FAIL sb_lane%0d: got %h@%h expected %h@%h", lane, wr_data, wr_addr, exp_word[lane], 32'h200);
      end
    end
    vectors++;
    if (done_cyc !== 5 || wr_cycles !== 2 || wdata_unstable) begin
      miscompares++; $display("FAIL sb_wr_wait: got done %0d wr %0d unstable %0b expected 5 2 0", done_cyc, wr_cycles, wdata_unstable);
    end
  endtask

  task automatic test_illegal();
    run_store(SZ_ILLEGAL, 32'h300, 32'h12345678, 32'h0, 0, 0, 1);
    vectors++;
    if (done_cyc !== 2 || err_seen !== 1'b1) begin
      miscompares++; $display("FAIL illegal_err: got done %0d err %0b expected 2 1", done_cyc, err_seen);
    end
    vectors++;
    if (rd_cycles !== 0 || wr_cycles !== 0 || err_stray) begin
      miscompares++; $display("FAIL illegal_access: got rd %0d wr %0d stray %0b expected 0 0 0", rd_cycles, wr_cycles, err_stray);
    end
    vectors++;
    if (post_done !== 1'b0) begin miscompares++; $display("FAIL illegal_pulse: got %0b expected 0", post_done); end
  endtask

  task automatic test_misalign();
    run_store(SZ_HALF, 32'h101, 32'hFFFF5566, 32'h11223344, 0, 0, 1);
`ifdef SWBH_MISALIGN_TRAP_EN
    vectors++;
    if (done_cyc !== 2 || err_seen !== 1'b1 || rd_cycles !== 0 || wr_cycles !== 0) begin
      miscompares++; $display("FAIL sh_misalign: got done %0d err %0b rd %0d wr %0d expected 2 1 0 0", done_cyc, err_seen, rd_cycles, wr_cycles);
    end
`else
    vectors++;
    if (done_cyc !== 4 || err_seen !== 1'b0 || wr_data !== 32'h11225566 || wr_addr !== 32'h100) begin
      miscompares++; $display("FAIL sh_misalign: got done %0d err %0b %h@%h expected 4 0 %h@%h", done_cyc, err_seen, wr_data, wr_addr, 32'h11225566, 32'h100);
    end
`endif
    run_store(SZ_WORD, 32'h103, 32'h12345678, 32'h0, 0, 0, 1);
`ifdef SWBH_MISALIGN_TRAP_EN
    vectors++;
    if (done_cyc !== 2 || err_seen !== 1'b1 || wr_cycles !== 0) begin
      miscompares++; $display("FAIL sw_misalign: got done %0d err %0b wr %0d expected 2 1 0", done_cyc, err_seen, wr_cycles);
    end
`else
    vectors++;
    if (done_cyc !== 3 || err_seen !== 1'b0 || wr_data !== 32'h12345678 || wr_addr !== 32'h100) begin
      miscompares++; $display("FAIL sw_misalign: got done %0d err %0b %h@%h expected 3 0 %h@%h", done_cyc, err_seen, wr_data, wr_addr, 32'h12345678, 32'h100);
    end
`endif
  endtask

  task automatic test_back_to_back();
    // start held through WRITE and DONE must not launch a second store
    run_store(SZ_WORD, 32'h400, 32'hA5A5A5A5, 32'h0, 0, 0, 3);
    vectors++;
    if (done_cyc !== 3 || wr_cycles !== 1) begin
      miscompares++; $display("FAIL b2b_first: got done %0d wr %0d expected 3 1", done_cyc, wr_cycles);
    end
    vectors++;
    if ({post_busy, post_done, post_wr} !== 3'b0) begin
      miscompares++; $display("FAIL b2b_ignored: got %b expected 000", {post_busy, post_done, post_wr});
    end
  endtask

  task automatic test_async_reset();
    bit saw_done;
    saw_done = 0;
    @(negedge clk);
    start = 1'b1; cnt = SZ_WORD; addr = 32'h500; wdata = 32'hCAFEF00D; mem_if.mem_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (mem_if.mem_wr !== 1'b1) begin miscompares++; $display("FAIL areset_wr_before: got %0b expected 1", mem_if.mem_wr); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (mem_if.mem_wr !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL areset_drop: got wr %0b busy %0b expected 0 0", mem_if.mem_wr, busy);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) saw_done = 1;
      if (i == 2) rst_n = 1'b1;
    end
    vectors++;
    if (saw_done) begin miscompares++; $display("FAIL areset_no_done: got 1 expected 0"); end
    run_store(SZ_WORD, 32'h504, 32'h0BADC0DE, 32'h0, 0, 0, 1);
    vectors++;
    if (done_cyc !== 3 || wr_data !== 32'h0BADC0DE || wr_addr !== 32'h504) begin
      miscompares++; $display("FAIL areset_recover: got done %0d %h@%h expected 3 %h@%h", done_cyc, wr_data, wr_addr, 32'h0BADC0DE, 32'h504);
    end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb();
    test_sh_wait();
    test_byte_lanes();
    test_illegal();
    test_misalign();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
